// File: rtl/ifu_fetch.sv
// ifu_fetch: sequential instruction fetch with several requests in flight,
// a PC-tagged instruction FIFO toward the decoder, and redirect/flush.
module ifu_fetch #(
    parameter int unsigned         ADDR_WIDTH      = 32,
    parameter int unsigned         PC_WIDTH        = 32,
    parameter int unsigned         INST_WIDTH      = 32,
    parameter int unsigned         BUF_DEPTH       = 4,
    parameter int unsigned         MAX_OUTSTANDING = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ifu_req_addr_vld,
    output logic [ADDR_WIDTH-1:0] ifu_req_addr,
    input  logic                  ifu_rsp_data_vld,
    input  logic [INST_WIDTH-1:0] ifu_rsp_data,
    input  logic                  redirect_vld,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  ifu_valid,
    input  logic                  ifu_ready,
    output logic [PC_WIDTH-1:0]   ifu_pc,
    output logic [INST_WIDTH-1:0] ifu_inst
);

    localparam int unsigned IW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PW = $clog2(BUF_DEPTH);

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   rsp_pc;
    logic [IW-1:0]         inflight;
    logic [IW-1:0]         drop;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [PC_WIDTH-1:0]   buf_pc   [BUF_DEPTH];
    logic [INST_WIDTH-1:0] buf_inst [BUF_DEPTH];

    logic [PC_WIDTH-1:0]   redirect_base;
    logic                  redirect_lsb_unused;
    logic                  rsp_fire;
    logic                  rsp_keep;
    logic                  pop;

    // Restart PC is word aligned; the two low bits carry no meaning
    assign redirect_base       = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign redirect_lsb_unused = |redirect_pc[1:0];

    assign ifu_req_addr = ADDR_WIDTH'(fetch_pc);
    assign ifu_pc       = buf_pc[rd_ptr];
    assign ifu_inst     = buf_inst[rd_ptr];

    // Issue credit, response classification and decoder handshake
    always_comb begin
        rsp_fire         = ifu_rsp_data_vld && (inflight != '0);
        rsp_keep         = rsp_fire && (drop == '0) && !redirect_vld;
        // Counting in-flight requests against free slots means every kept
        // response already owns a FIFO entry when it arrives
        ifu_req_addr_vld = !rst && !redirect_vld
                           && (32'(inflight) < MAX_OUTSTANDING)
                           && ((32'(inflight) + 32'(count)) < BUF_DEPTH);
        ifu_valid        = (count != '0) && !redirect_vld;
        pop              = ifu_valid && ifu_ready;
    end

    // Fetch/response bookkeeping and FIFO pointers; redirect overrides all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_vld) begin
            fetch_pc <= redirect_base;
            rsp_pc   <= redirect_base;
            inflight <= inflight - IW'(rsp_fire);
            // Responses already marked for discard are a subset of the
            // in-flight ones, so after a flush every outstanding beat is stale
            drop     <= inflight - IW'(rsp_fire);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (ifu_req_addr_vld) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end
            inflight <= inflight + IW'(ifu_req_addr_vld) - IW'(rsp_fire);
            if (rsp_fire && (drop != '0)) begin
                drop <= drop - IW'(1);
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + PC_WIDTH'(4);
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(rsp_keep) - CW'(pop);
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_pc[i]   <= '0;
                buf_inst[i] <= '0;
            end
        end else if (rsp_keep) begin
            buf_pc[wr_ptr]   <= rsp_pc;
            buf_inst[wr_ptr] <= ifu_rsp_data;
        end
    end

    // Memory must never answer when nothing is outstanding
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ifu_rsp_data_vld && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed checks of ifu_fetch against fixed-latency memory models.
module tb_ifu_fetch;

    localparam logic [31:0] KEY  = 32'hC0DE_0000;
    localparam int          LAT1 = 3;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        d0_req_vld;
    logic [31:0] d0_req_addr;
    logic        d0_rsp_vld  = 1'b0;
    logic [31:0] d0_rsp_data = '0;
    logic        d0_redir    = 1'b0;
    logic [31:0] d0_redir_pc = '0;
    logic        d0_valid;
    logic        d0_ready    = 1'b0;
    logic [31:0] d0_pc;
    logic [31:0] d0_inst;

    logic        d1_req_vld;
    logic [31:0] d1_req_addr;
    logic        d1_rsp_vld  = 1'b0;
    logic [31:0] d1_rsp_data = '0;
    logic        d1_redir    = 1'b0;
    logic [31:0] d1_redir_pc = '0;
    logic        d1_valid;
    logic        d1_ready    = 1'b1;
    logic [31:0] d1_pc;
    logic [31:0] d1_inst;

    int lat0   = 1;
    int checks = 0;
    int errors = 0;

    ifu_fetch dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_addr_vld (d0_req_vld),
        .ifu_req_addr     (d0_req_addr),
        .ifu_rsp_data_vld (d0_rsp_vld),
        .ifu_rsp_data     (d0_rsp_data),
        .redirect_vld     (d0_redir),
        .redirect_pc      (d0_redir_pc),
        .ifu_valid        (d0_valid),
        .ifu_ready        (d0_ready),
        .ifu_pc           (d0_pc),
        .ifu_inst         (d0_inst)
    );

    ifu_fetch #(.MAX_OUTSTANDING(2)) dut2 (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_addr_vld (d1_req_vld),
        .ifu_req_addr     (d1_req_addr),
        .ifu_rsp_data_vld (d1_rsp_vld),
        .ifu_rsp_data     (d1_rsp_data),
        .redirect_vld     (d1_redir),
        .redirect_pc      (d1_redir_pc),
        .ifu_valid        (d1_valid),
        .ifu_ready        (d1_ready),
        .ifu_pc           (d1_pc),
        .ifu_inst         (d1_inst)
    );

    always #5 clk = ~clk;

    // Memory models: a request seen at edge t answers at edge t+L, in order
    mreq_t       q0[$];
    mreq_t       q1[$];
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    int          cyc0 = 0, cyc1 = 0;

    always @(negedge clk) begin
        #1;
        m0_req  = d0_req_vld;
        m0_addr = d0_req_addr;
        m1_req  = d1_req_vld;
        m1_addr = d1_req_addr;
    end

    always @(posedge clk) begin
        cyc0++;
        if (rst) q0.delete();
        else if (m0_req) q0.push_back('{addr: m0_addr, due: cyc0 + lat0});
        #1;
        if (!rst && q0.size() != 0 && q0[0].due == cyc0 + 1) begin
            d0_rsp_vld  = 1'b1;
            d0_rsp_data = q0[0].addr ^ KEY;
            q0.delete(0);
        end else begin
            d0_rsp_vld = 1'b0;
        end
    end

    always @(posedge clk) begin
        cyc1++;
        if (rst) q1.delete();
        else if (m1_req) q1.push_back('{addr: m1_addr, due: cyc1 + LAT1});
        #1;
        if (!rst && q1.size() != 0 && q1[0].due == cyc1 + 1) begin
            d1_rsp_vld  = 1'b1;
            d1_rsp_data = q1[0].addr ^ KEY;
            q1.delete(0);
        end else begin
            d1_rsp_vld = 1'b0;
        end
    end

    // Leaves the bench at the negedge where rst drops (edge 1 is next)
    task automatic reset_dut(input int lat, input logic rdy);
        @(negedge clk);
        rst      = 1'b1;
        d0_redir = 1'b0;
        d0_ready = rdy;
        lat0     = lat;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (d0_req_vld !== 1'b0 || d0_valid !== 1'b0 || d1_req_vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_vld: got req=%b valid=%b req2=%b, expected 0 0 0", d0_req_vld, d0_valid, d1_req_vld);
        end
        checks++;
        if (d0_pc !== 32'h0 || d0_inst !== 32'h0 || d0_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_val: got pc=%h inst=%h addr=%h, expected all 0", d0_pc, d0_inst, d0_req_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] epc;
        reset_dut(1, 1'b1);
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++;
            if (d0_req_vld !== 1'b1 || d0_req_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_req k=%0d: got vld=%b addr=%h, expected vld=1 addr=%h", k, d0_req_vld, d0_req_addr, 32'(4 * k));
            end
            checks++;
            if (d0_valid !== (k >= 2)) begin
                errors++;
                $display("FAIL seq_valid k=%0d: got %b expected %b", k, d0_valid, (k >= 2));
            end
            if (k >= 2) begin
                epc = 32'(4 * (k - 2));
                checks++;
                if (d0_pc !== epc || d0_inst !== (epc ^ KEY)) begin
                    errors++;
                    $display("FAIL seq_data k=%0d: got pc=%h inst=%h expected pc=%h inst=%h", k, d0_pc, d0_inst, epc, epc ^ KEY);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] epc;
        reset_dut(1, 1'b0);
        for (int k = 0; k < 14; k++) begin
            if (k == 9) d0_ready = 1'b1;
            #1;
            if (k <= 9) begin
                checks++;
                if (d0_req_vld !== (k <= 3)) begin
                    errors++;
                    $display("FAIL bp_req k=%0d: got %b expected %b", k, d0_req_vld, (k <= 3));
                end
            end
            if (k >= 2) begin
                epc = (k <= 9) ? 32'h0 : 32'(4 * (k - 9));
                checks++;
                if (d0_valid !== 1'b1 || d0_pc !== epc || d0_inst !== (epc ^ KEY)) begin
                    errors++;
                    $display("FAIL bp_head k=%0d: got valid=%b pc=%h inst=%h expected valid=1 pc=%h", k, d0_valid, d0_pc, d0_inst, epc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_max_outstanding();
        int          out2;
        logic        evld;
        logic [31:0] eaddr;
        logic [31:0] epc;
        out2 = 0;
        reset_dut(1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            #1;
            evld  = ((k % 4) < 2);
            eaddr = 32'(4 * (2 * (k / 4) + (k % 4)));
            checks++;
            if (d1_req_vld !== evld || (evld && d1_req_addr !== eaddr)) begin
                errors++;
                $display("FAIL mo_req k=%0d: got vld=%b addr=%h expected vld=%b addr=%h", k, d1_req_vld, d1_req_addr, evld, eaddr);
            end
            if (d1_req_vld === 1'b1) out2++;
            if (d1_rsp_vld === 1'b1) out2--;
            checks++;
            if (out2 > 2) begin
                errors++;
                $display("FAIL mo_inflight k=%0d: got %0d expected <= 2", k, out2);
            end
            evld = (k >= 4) && ((k % 4) < 2);
            epc  = 32'(4 * (2 * (k / 4 - 1) + (k % 4)));
            checks++;
            if (d1_valid !== evld || (evld && (d1_pc !== epc || d1_inst !== (epc ^ KEY)))) begin
                errors++;
                $display("FAIL mo_out k=%0d: got valid=%b pc=%h expected valid=%b pc=%h", k, d1_valid, d1_pc, evld, epc);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] epc;
        reset_dut(4, 1'b1);
        for (int k = 0; k < 13; k++) begin
            if (k == 3) begin
                d0_redir    = 1'b1;
                d0_redir_pc = 32'h0000_0103;
            end
            if (k == 4) d0_redir = 1'b0;
            #1;
            if (k == 3) begin
                checks++;
                if (d0_req_vld !== 1'b0 || d0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_cycle: got req=%b valid=%b expected 0 0", d0_req_vld, d0_valid);
                end
            end
            if (k == 4) begin
                checks++;
                if (d0_req_vld !== 1'b1 || d0_req_addr !== 32'h100) begin
                    errors++;
                    $display("FAIL redir_req: got vld=%b addr=%h expected vld=1 addr=00000100", d0_req_vld, d0_req_addr);
                end
            end
            if (k >= 4 && k <= 8) begin
                checks++;
                if (d0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_drop k=%0d: got valid=%b pc=%h expected valid=0", k, d0_valid, d0_pc);
                end
            end
            if (k >= 9) begin
                epc = 32'h100 + 32'(4 * (k - 9));
                checks++;
                if (d0_valid !== 1'b1 || d0_pc !== epc || d0_inst !== (epc ^ KEY)) begin
                    errors++;
                    $display("FAIL redir_data k=%0d: got valid=%b pc=%h inst=%h expected pc=%h", k, d0_valid, d0_pc, d0_inst, epc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_with_beat();
        logic [31:0] epc;
        reset_dut(1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                d0_redir    = 1'b1;
                d0_redir_pc = 32'h0000_0200;
            end
            if (k == 6) d0_redir = 1'b0;
            #1;
            if (k == 5) begin
                checks++;
                if (d0_valid !== 1'b0 || d0_req_vld !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_cycle: got valid=%b req=%b expected 0 0", d0_valid, d0_req_vld);
                end
            end
            if (k == 6) begin
                checks++;
                if (d0_req_vld !== 1'b1 || d0_req_addr !== 32'h200 || d0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_req: got vld=%b addr=%h valid=%b expected 1 00000200 0", d0_req_vld, d0_req_addr, d0_valid);
                end
            end
            if (k == 7) begin
                checks++;
                if (d0_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rb_flush: got valid=%b pc=%h expected valid=0", d0_valid, d0_pc);
                end
            end
            if (k >= 8) begin
                epc = 32'h200 + 32'(4 * (k - 8));
                checks++;
                if (d0_valid !== 1'b1 || d0_pc !== epc || d0_inst !== (epc ^ KEY)) begin
                    errors++;
                    $display("FAIL rb_data k=%0d: got valid=%b pc=%h inst=%h expected pc=%h", k, d0_valid, d0_pc, d0_inst, epc);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        reset_dut(1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) d0_ready = 1'b0;
            #1;
            if (k == 9) begin
                checks++;
                if (d0_valid !== 1'b1 || d0_pc !== 32'hC || d0_req_vld !== 1'b0 || d0_req_addr !== 32'h1C) begin
                    errors++;
                    $display("FAIL mid_full: got valid=%b pc=%h req=%b addr=%h expected 1 0000000c 0 0000001c", d0_valid, d0_pc, d0_req_vld, d0_req_addr);
                end
                rst = 1'b1;
                #1;
                checks++;
                if (d0_req_vld !== 1'b0 || d0_valid !== 1'b0 || d0_pc !== 32'h0 || d0_inst !== 32'h0 || d0_req_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_reset: got req=%b valid=%b pc=%h inst=%h addr=%h expected all 0", d0_req_vld, d0_valid, d0_pc, d0_inst, d0_req_addr);
                end
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        d0_ready = 1'b1;
        rst      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (k < 2) begin
                checks++;
                if (d0_req_vld !== 1'b1 || d0_req_addr !== 32'(4 * k)) begin
                    errors++;
                    $display("FAIL mid_restart k=%0d: got vld=%b addr=%h expected vld=1 addr=%h", k, d0_req_vld, d0_req_addr, 32'(4 * k));
                end
            end else begin
                checks++;
                if (d0_valid !== 1'b1 || d0_pc !== 32'h0 || d0_inst !== KEY) begin
                    errors++;
                    $display("FAIL mid_first: got valid=%b pc=%h inst=%h expected 1 00000000 %h", d0_valid, d0_pc, d0_inst, KEY);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_max_outstanding();
        test_redirect();
        test_redirect_with_beat();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
